// File: rtl/qspi_dma_burst_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_dma_burst_engine_if
//  Description : AXI4 read/write channel bundle between the QSPI DMA burst
//                engine (master) and the system interconnect (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface qspi_dma_burst_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_BYTES = DATA_WIDTH / 8;

    // Write address channel
    logic [ADDR_WIDTH-1:0] awaddr_o;
    logic [7:0]            awlen_o;
    logic [1:0]            awburst_o;
    logic                  awvalid_o;
    logic                  awready_i;
    // Write data channel
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [c_BYTES-1:0]    wstrb_o;
    logic                  wlast_o;
    logic                  wvalid_o;
    logic                  wready_i;
    // Write response channel
    logic [1:0]            bresp_i;
    logic                  bvalid_i;
    logic                  bready_o;
    // Read address channel
    logic [ADDR_WIDTH-1:0] araddr_o;
    logic [7:0]            arlen_o;
    logic [1:0]            arburst_o;
    logic                  arvalid_o;
    logic                  arready_i;
    // Read data channel
    logic [DATA_WIDTH-1:0] rdata_i;
    logic [1:0]            rresp_i;
    logic                  rlast_i;
    logic                  rvalid_i;
    logic                  rready_o;

    modport master (
        output awaddr_o, awlen_o, awburst_o, awvalid_o,
        input  awready_i,
        output wdata_o, wstrb_o, wlast_o, wvalid_o,
        input  wready_i,
        input  bresp_i, bvalid_i,
        output bready_o,
        output araddr_o, arlen_o, arburst_o, arvalid_o,
        input  arready_i,
        input  rdata_i, rresp_i, rlast_i, rvalid_i,
        output rready_o
    );

    modport slave (
        input  awaddr_o, awlen_o, awburst_o, awvalid_o,
        output awready_i,
        input  wdata_o, wstrb_o, wlast_o, wvalid_o,
        output wready_i,
        output bresp_i, bvalid_i,
        input  bready_o,
        input  araddr_o, arlen_o, arburst_o, arvalid_o,
        output arready_i,
        output rdata_i, rresp_i, rlast_i, rvalid_i,
        input  rready_o
    );
endinterface
`default_nettype wire

// File: rtl/qspi_dma_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_dma_burst_engine
//  Description : Multi-beat AXI4 DMA between system memory and the QSPI
//                TX/RX FIFOs with byte-granular lengths, 4 KB splitting,
//                FIFO-space gated burst issue and error abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_dma_burst_engine #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int LEVEL_WIDTH   = 5,
    parameter int MAX_BURST     = 16
) (
    input  wire logic                   clk,
    input  wire logic                   resetn,
    input  wire logic                   start_i,
    input  wire logic                   dir_i,
    input  wire logic [7:0]             burst_i,
    input  wire logic                   incr_addr_i,
    input  wire logic [ADDR_WIDTH-1:0]  addr_i,
    input  wire logic [31:0]            len_i,
    input  wire logic [LEVEL_WIDTH-1:0] tx_level_i,
    output logic      [DATA_WIDTH-1:0]  fifo_tx_data_o,
    output logic                        fifo_tx_we_o,
    input  wire logic [LEVEL_WIDTH-1:0] rx_level_i,
    input  wire logic [DATA_WIDTH-1:0]  fifo_rx_data_i,
    output logic                        fifo_rx_re_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        busy_o,
    qspi_dma_burst_engine_if.master     axi
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_LGB   = $clog2(c_BYTES);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CALC   = 4'd1,
        S_AR     = 4'd2,
        S_R      = 4'd3,
        S_AW     = 4'd4,
        S_WFETCH = 4'd5,
        S_WDATA  = 4'd6,
        S_B      = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_beats_left;
    logic [c_LGB-1:0]      r_tail;
    logic                  r_dir;
    logic                  r_incr;
    logic [8:0]            r_burst;
    logic [8:0]            r_n;
    logic [8:0]            r_beat_cnt;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_fetch_ph;

    logic [32:0]           w_len_round;
    logic [31:0]           w_start_beats;
    logic [8:0]            w_burst_clamp;
    logic [31:0]           w_to_4k;
    logic [8:0]            w_n;
    logic                  w_gate;
    logic                  w_r_end;
    logic                  w_b_end;
    logic                  w_burst_end;
    logic                  w_resp_err;
    logic                  w_err_next;
    logic                  w_more;
    logic                  w_wlast;
    logic                  w_last_xfer_beat;
    logic [c_BYTES-1:0]    w_tail_mask;

    // Start-time derivations: beat count rounded up, burst request clamped to 1..MAX_BURST
    assign w_len_round   = {1'b0, len_i} + 33'(c_BYTES - 1);
    assign w_start_beats = 32'(w_len_round >> c_LGB);
    assign w_burst_clamp = (burst_i == 8'd0)                   ? 9'd1 :
                           ({1'b0, burst_i} > 9'(MAX_BURST))   ? 9'(MAX_BURST) :
                                                                 {1'b0, burst_i};

    // Beats remaining before the current address crosses a 4 KB page
    assign w_to_4k = (32'd4096 - {20'd0, r_addr[11:0]}) >> c_LGB;

    // Burst size for the next transaction: min(beats left, burst, 4 KB room)
    always_comb begin
        w_n = r_burst;
        if (r_beats_left < {23'd0, r_burst})
            w_n = r_beats_left[8:0];
        if (r_incr && (w_to_4k < {23'd0, w_n}))
            w_n = w_to_4k[8:0];
    end

    // Only issue a burst once the FIFO can absorb/supply all of its beats
    assign w_gate = r_dir ? (32'(rx_level_i) >= 32'(w_n))
                          : ((32'(tx_level_i) + 32'(w_n)) <= 32'(TX_FIFO_DEPTH));

    assign w_r_end     = (r_state == S_R) && axi.rvalid_i && axi.rlast_i;
    assign w_b_end     = (r_state == S_B) && axi.bvalid_i;
    assign w_burst_end = w_r_end || w_b_end;
    assign w_resp_err  = ((r_state == S_R) && axi.rvalid_i && (axi.rresp_i != 2'b00)) ||
                         ((r_state == S_B) && axi.bvalid_i && (axi.bresp_i != 2'b00));
    assign w_err_next  = r_err || w_resp_err;
    assign w_more      = (r_beats_left != {23'd0, r_n});

    assign w_wlast          = (r_beat_cnt == (r_n - 9'd1));
    assign w_last_xfer_beat = ((32'(r_beat_cnt) + 32'd1) == r_beats_left);

    // Byte lanes carrying valid data on a partial final beat
    always_comb begin
        w_tail_mask = '0;
        for (int i = 0; i < c_BYTES; i++)
            w_tail_mask[i] = (i < int'(r_tail));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_next = (len_i == 32'd0) ? S_DONE : S_CALC;
            S_CALC:   if (w_gate) w_next = r_dir ? S_AW : S_AR;
            S_AR:     if (axi.arready_i) w_next = S_R;
            S_R:      if (w_r_end) w_next = (w_more && !w_err_next) ? S_CALC : S_DONE;
            S_AW:     if (axi.awready_i) w_next = S_WFETCH;
            S_WFETCH: if (r_fetch_ph) w_next = S_WDATA;
            S_WDATA:  if (axi.wready_i) w_next = w_wlast ? S_B : S_WFETCH;
            S_B:      if (w_b_end) w_next = (w_more && !w_err_next) ? S_CALC : S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: address, beat counters, fetched write word, error flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr       <= '0;
            r_beats_left <= '0;
            r_tail       <= '0;
            r_dir        <= 1'b0;
            r_incr       <= 1'b0;
            r_burst      <= 9'd1;
            r_n          <= '0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
            r_wdata      <= '0;
            r_fetch_ph   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr       <= addr_i & ~ADDR_WIDTH'(c_BYTES - 1);
                        r_beats_left <= w_start_beats;
                        r_tail       <= len_i[c_LGB-1:0];
                        r_dir        <= dir_i;
                        r_incr       <= incr_addr_i;
                        r_burst      <= w_burst_clamp;
                        r_err        <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_n        <= w_n;
                    r_beat_cnt <= '0;
                    r_fetch_ph <= 1'b0;
                end
                S_WFETCH: begin
                    // Pop on the first cycle, RX FIFO data is valid on the second
                    r_fetch_ph <= ~r_fetch_ph;
                    if (r_fetch_ph)
                        r_wdata <= fifo_rx_data_i;
                end
                S_WDATA: begin
                    if (axi.wready_i)
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                end
                default: ;
            endcase

            if (w_resp_err)
                r_err <= 1'b1;

            if (w_burst_end) begin
                r_beats_left <= r_beats_left - {23'd0, r_n};
                if (r_incr)
                    r_addr <= r_addr + (ADDR_WIDTH'(r_n) << c_LGB);
            end
        end
    end

    // AXI read channels
    assign axi.arvalid_o = (r_state == S_AR);
    assign axi.araddr_o  = axi.arvalid_o ? r_addr : '0;
    assign axi.arlen_o   = axi.arvalid_o ? 8'(r_n - 9'd1) : 8'd0;
    assign axi.arburst_o = (axi.arvalid_o && r_incr) ? 2'b01 : 2'b00;
    assign axi.rready_o  = (r_state == S_R);

    // AXI write channels
    assign axi.awvalid_o = (r_state == S_AW);
    assign axi.awaddr_o  = axi.awvalid_o ? r_addr : '0;
    assign axi.awlen_o   = axi.awvalid_o ? 8'(r_n - 9'd1) : 8'd0;
    assign axi.awburst_o = (axi.awvalid_o && r_incr) ? 2'b01 : 2'b00;
    assign axi.wvalid_o  = (r_state == S_WDATA);
    assign axi.wdata_o   = axi.wvalid_o ? r_wdata : '0;
    assign axi.wlast_o   = axi.wvalid_o && w_wlast;
    assign axi.wstrb_o   = !axi.wvalid_o                              ? '0 :
                           (w_last_xfer_beat && (r_tail != '0))       ? w_tail_mask :
                                                                        '1;
    assign axi.bready_o  = (r_state == S_B);

    // FIFO side and status
    assign fifo_tx_we_o   = (r_state == S_R) && axi.rvalid_i;
    assign fifo_tx_data_o = fifo_tx_we_o ? axi.rdata_i : '0;
    assign fifo_rx_re_o   = (r_state == S_WFETCH) && !r_fetch_ph;
    assign done_o         = (r_state == S_DONE);
    assign err_o          = (r_state == S_DONE) && r_err;
    assign busy_o         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qspi_dma_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_dma_burst_engine
//  Description : Directed bench for qspi_dma_burst_engine with an AXI memory
//                slave, RX FIFO source and TX FIFO capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_dma_burst_engine;

    localparam int c_AW = 32;
    localparam int c_DW = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        dir_i = 1'b0;
    logic [7:0]  burst_i = 8'd0;
    logic        incr_addr_i = 1'b1;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] len_i = 32'd0;
    logic [4:0]  tx_level_i = 5'd0;
    logic [4:0]  rx_level_i = 5'd0;
    logic [31:0] fifo_rx_data_i;
    logic [31:0] fifo_tx_data_o;
    logic        fifo_tx_we_o;
    logic        fifo_rx_re_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;

    qspi_dma_burst_engine_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) axi ();

    qspi_dma_burst_engine #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .TX_FIFO_DEPTH(16),
        .LEVEL_WIDTH(5), .MAX_BURST(16)
    ) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .dir_i(dir_i),
        .burst_i(burst_i), .incr_addr_i(incr_addr_i), .addr_i(addr_i),
        .len_i(len_i), .tx_level_i(tx_level_i), .fifo_tx_data_o(fifo_tx_data_o),
        .fifo_tx_we_o(fifo_tx_we_o), .rx_level_i(rx_level_i),
        .fifo_rx_data_i(fifo_rx_data_i), .fifo_rx_re_o(fifo_rx_re_o),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .axi(axi)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic clr_logs = 1'b0;
    int err_aw_idx = 0;
    logic [31:0] rx_src [0:7];

    // Slave-side logs
    logic [31:0] ar_addr_log [0:7];
    logic [7:0]  ar_len_log  [0:7];
    logic [1:0]  ar_burst_log[0:7];
    logic [31:0] aw_addr_log [0:7];
    logic [7:0]  aw_len_log  [0:7];
    int ar_cnt, aw_cnt, w_cnt, wlast_at;
    logic [3:0]  last_strb;
    logic [31:0] wmem [0:2047];
    int rd_left;
    logic [31:0] rd_addr;
    logic rd_incr;
    logic [31:0] wr_addr;
    logic b_pend;

    // Monitor logs
    logic [31:0] tx_log [0:63];
    int tx_cnt, done_cnt, err_done, err_alone, rx_ptr;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a >> 2) * 32'h01010101;
    endfunction

    // AXI memory slave: reads return pat(addr), writes land in wmem
    always @(posedge clk) begin
        if (!resetn || clr_logs) begin
            axi.arready_i <= 1'b1;
            axi.awready_i <= 1'b1;
            axi.wready_i  <= 1'b1;
            axi.rvalid_i  <= 1'b0;
            axi.rlast_i   <= 1'b0;
            axi.rresp_i   <= 2'b00;
            axi.rdata_i   <= 32'd0;
            axi.bvalid_i  <= 1'b0;
            axi.bresp_i   <= 2'b00;
            rd_left = 0;
            b_pend  = 1'b0;
            if (clr_logs) begin
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; wlast_at = 0; last_strb = 4'd0;
                for (int i = 0; i < 2048; i++) wmem[i] = 32'd0;
            end
        end else begin
            if (axi.rvalid_i && axi.rready_o) begin
                rd_left = rd_left - 1;
                if (rd_incr) rd_addr = rd_addr + 32'd4;
            end
            if (axi.arvalid_o && axi.arready_i) begin
                if (ar_cnt < 8) begin
                    ar_addr_log[ar_cnt]  = axi.araddr_o;
                    ar_len_log[ar_cnt]   = axi.arlen_o;
                    ar_burst_log[ar_cnt] = axi.arburst_o;
                end
                ar_cnt  = ar_cnt + 1;
                rd_left = int'(axi.arlen_o) + 1;
                rd_addr = axi.araddr_o;
                rd_incr = (axi.arburst_o == 2'b01);
            end
            if (rd_left > 0) begin
                axi.rvalid_i <= 1'b1;
                axi.rdata_i  <= pat(rd_addr);
                axi.rlast_i  <= (rd_left == 1);
            end else begin
                axi.rvalid_i <= 1'b0;
                axi.rlast_i  <= 1'b0;
            end
            if (axi.awvalid_o && axi.awready_i) begin
                if (aw_cnt < 8) begin
                    aw_addr_log[aw_cnt] = axi.awaddr_o;
                    aw_len_log[aw_cnt]  = axi.awlen_o;
                end
                aw_cnt  = aw_cnt + 1;
                wr_addr = axi.awaddr_o;
            end
            if (axi.wvalid_o && axi.wready_i) begin
                w_cnt = w_cnt + 1;
                for (int b = 0; b < 4; b++)
                    if (axi.wstrb_o[b]) wmem[wr_addr[12:2]][8*b +: 8] = axi.wdata_o[8*b +: 8];
                if (axi.wlast_o) begin
                    wlast_at  = w_cnt;
                    last_strb = axi.wstrb_o;
                    b_pend    = 1'b1;
                end
                wr_addr = wr_addr + 32'd4;
            end
            if (b_pend && !axi.bvalid_i) begin
                axi.bvalid_i <= 1'b1;
                axi.bresp_i  <= (aw_cnt == err_aw_idx) ? 2'b10 : 2'b00;
                b_pend = 1'b0;
            end else if (axi.bvalid_i && axi.bready_o) begin
                axi.bvalid_i <= 1'b0;
            end
        end
    end

    // RX FIFO source: data valid the cycle after a pop
    always @(posedge clk) begin
        if (clr_logs) rx_ptr = 0;
        else if (fifo_rx_re_o) begin
            fifo_rx_data_i <= rx_src[rx_ptr[2:0]];
            rx_ptr = rx_ptr + 1;
        end
    end

    // TX FIFO capture and completion monitor
    always @(posedge clk) begin
        if (clr_logs) begin
            tx_cnt = 0; done_cnt = 0; err_done = 0; err_alone = 0;
        end else begin
            if (fifo_tx_we_o) begin
                if (tx_cnt < 64) tx_log[tx_cnt] = fifo_tx_data_o;
                tx_cnt = tx_cnt + 1;
            end
            if (done_o) done_cnt = done_cnt + 1;
            if (err_o && done_o)  err_done  = err_done + 1;
            if (err_o && !done_o) err_alone = err_alone + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic dir, input logic [31:0] a, input logic [31:0] l,
                        input logic [7:0] b, input logic inc);
        @(negedge clk) clr_logs = 1'b1;
        @(negedge clk) clr_logs = 1'b0;
        dir_i = dir; addr_i = a; len_i = l; burst_i = b; incr_addr_i = inc;
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, done_cnt == 0}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rx_src[0] = 32'hA5A5A5A5; rx_src[1] = 32'h5A5A5A5A;
        rx_src[2] = 32'hDEADBEEF; rx_src[3] = 32'hC0DECAFE;
        rx_src[4] = 32'h11111111; rx_src[5] = 32'h22222222;
        rx_src[6] = 32'h33333333; rx_src[7] = 32'h44444444;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_outs", {23'd0, axi.arvalid_o, axi.awvalid_o, axi.wvalid_o, axi.rready_o,
                         axi.bready_o, fifo_rx_re_o, fifo_tx_we_o, done_o, err_o}, 32'd0);
        resetn = 1'b1;

        // Read 64 bytes in two 8-beat INCR bursts
        kick(1'b0, 32'h0, 32'd64, 8'd8, 1'b1);
        wait_done("t1_timeout", 200);
        chk("t1_ar_cnt", ar_cnt, 2);
        chk("t1_ar0_addr", ar_addr_log[0], 32'h00);
        chk("t1_ar0_len", {24'd0, ar_len_log[0]}, 7);
        chk("t1_ar0_burst", {30'd0, ar_burst_log[0]}, 1);
        chk("t1_ar1_addr", ar_addr_log[1], 32'h20);
        chk("t1_ar1_len", {24'd0, ar_len_log[1]}, 7);
        chk("t1_tx_cnt", tx_cnt, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t1_tx%0d", i), tx_log[i], 32'(i) * 32'h01010101);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", err_done + err_alone, 0);
        chk("t1_busy_after", {31'd0, busy_o}, 32'd0);

        // Write 14 bytes from RX FIFO: partial tail strobe
        rx_level_i = 5'd4;
        kick(1'b1, 32'h40, 32'd14, 8'd4, 1'b1);
        wait_done("t2_timeout", 200);
        chk("t2_aw_cnt", aw_cnt, 1);
        chk("t2_aw_addr", aw_addr_log[0], 32'h40);
        chk("t2_aw_len", {24'd0, aw_len_log[0]}, 3);
        chk("t2_w_cnt", w_cnt, 4);
        chk("t2_wlast_at", wlast_at, 4);
        chk("t2_last_strb", {28'd0, last_strb}, 32'h3);
        chk("t2_mem16", wmem[16], 32'hA5A5A5A5);
        chk("t2_mem17", wmem[17], 32'h5A5A5A5A);
        chk("t2_mem18", wmem[18], 32'hDEADBEEF);
        chk("t2_mem19", wmem[19], 32'h0000CAFE);
        chk("t2_err", err_done + err_alone, 0);
        rx_level_i = 5'd0;

        // 4 KB boundary split
        kick(1'b0, 32'hFF8, 32'd32, 8'd16, 1'b1);
        wait_done("t3_timeout", 200);
        chk("t3_ar_cnt", ar_cnt, 2);
        chk("t3_ar0_addr", ar_addr_log[0], 32'hFF8);
        chk("t3_ar0_len", {24'd0, ar_len_log[0]}, 1);
        chk("t3_ar1_addr", ar_addr_log[1], 32'h1000);
        chk("t3_ar1_len", {24'd0, ar_len_log[1]}, 5);
        chk("t3_tx_cnt", tx_cnt, 8);
        chk("t3_tx0", tx_log[0], pat(32'hFF8));
        chk("t3_tx7", tx_log[7], pat(32'h1014));

        // TX free-space gating
        tx_level_i = 5'd14;
        kick(1'b0, 32'h0, 32'd16, 8'd4, 1'b1);
        repeat (10) @(negedge clk);
        chk("t4_no_ar_14", ar_cnt, 0);
        chk("t4_arvalid_14", {31'd0, axi.arvalid_o}, 32'd0);
        chk("t4_busy", {31'd0, busy_o}, 32'd1);
        tx_level_i = 5'd13;
        repeat (5) @(negedge clk);
        chk("t4_no_ar_13", ar_cnt, 0);
        tx_level_i = 5'd12;
        wait_done("t4_timeout", 100);
        chk("t4_ar_cnt", ar_cnt, 1);
        chk("t4_ar_len", {24'd0, ar_len_log[0]}, 3);
        chk("t4_tx_cnt", tx_cnt, 4);
        tx_level_i = 5'd0;

        // FIXED burst re-reads the same word
        kick(1'b0, 32'h10, 32'd8, 8'd2, 1'b0);
        wait_done("tf_timeout", 100);
        chk("tf_ar_burst", {30'd0, ar_burst_log[0]}, 0);
        chk("tf_ar_len", {24'd0, ar_len_log[0]}, 1);
        chk("tf_tx1", tx_log[1], 32'h04040404);

        // Zero length: no AXI traffic
        kick(1'b0, 32'h0, 32'd0, 8'd4, 1'b1);
        wait_done("tz_timeout", 5);
        chk("tz_axi", ar_cnt + aw_cnt, 0);

        // Error on first write burst aborts the second
        rx_level_i = 5'd8;
        err_aw_idx = 1;
        kick(1'b1, 32'h100, 32'd32, 8'd4, 1'b1);
        wait_done("t5_timeout", 200);
        chk("t5_aw_cnt", aw_cnt, 1);
        chk("t5_w_cnt", w_cnt, 4);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_err_with_done", err_done, 1);
        chk("t5_err_alone", err_alone, 0);
        err_aw_idx = 0;
        rx_level_i = 5'd0;

        // Reset mid-read, then a clean transfer
        kick(1'b0, 32'h0, 32'd64, 8'd8, 1'b1);
        begin
            int k = 0;
            while (tx_cnt < 3 && k < 50) begin @(negedge clk); k++; end
            chk("t6_reach_r", {31'd0, tx_cnt < 3}, 32'd0);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_valids", {27'd0, axi.arvalid_o, axi.awvalid_o, axi.wvalid_o,
                          axi.rready_o, fifo_tx_we_o}, 32'd0);
        resetn = 1'b1;
        kick(1'b0, 32'h0, 32'd16, 8'd4, 1'b1);
        wait_done("t6_timeout", 100);
        chk("t6_ar_cnt", ar_cnt, 1);
        chk("t6_tx_cnt", tx_cnt, 4);
        chk("t6_tx3", tx_log[3], 32'h03030303);
        chk("t6_err", err_done, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
